// File: rtl/conv_weight_manager.sv
// Weight RAM manager: packs DMA load beats into wide words and serves fixed-latency reads.
// Optional load checksum output is enabled by defining WT_MGR_CHECKSUM_EN.
module conv_weight_manager #(
   parameter int WT_ADDR_WIDTH  = 12,
   parameter int WT_LATENCY     = 3,
   parameter int LOAD_W         = 64,
   parameter int BEATS_PER_WORD = 9
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [WT_ADDR_WIDTH-1:0]          cfg_load_base,
   input  logic [WT_ADDR_WIDTH-1:0]          cfg_load_words,
   input  logic                              load_go,
   input  logic                              ld_valid,
   output logic                              ld_ready,
   input  logic [LOAD_W-1:0]                 ld_data,
   output logic                              load_done,
   output logic                              wt_data_ready,
   input  logic                              wt_rd_en,
   input  logic [WT_ADDR_WIDTH-1:0]          wt_rd_addr,
   output logic                              wt_rd_valid,
   output logic [LOAD_W*BEATS_PER_WORD-1:0]  wt_rd_data,
`ifdef WT_MGR_CHECKSUM_EN
   output logic [31:0]                       load_checksum,
`endif
   output logic                              rd_err
);

   localparam int WT_W    = LOAD_W * BEATS_PER_WORD;
   localparam int DEPTH   = 1 << WT_ADDR_WIDTH;
   localparam int BEAT_CW = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
   localparam int NS      = WT_LATENCY - 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY} state_t;

   state_t                     state, state_next;
   logic                       load_start, load_finish, beat_fire, last_wr;
   logic [WT_ADDR_WIDTH-1:0]   base_q, words_q, word_cnt, fill_cnt, wr_addr;
   logic [BEAT_CW-1:0]         beat_cnt;
   logic [WT_W-1:0]            pack, pack_next, wr_word;
   logic                       wr_pend;

   logic [WT_W-1:0]            ram [DEPTH];
   logic [WT_ADDR_WIDTH-1:0]   addr_q;
   logic                       acc_q;
   logic [NS-1:0]              rv;
   logic [WT_W-1:0]            rd_pipe [NS];

   assign beat_fire = ld_valid && ld_ready;
   assign last_wr   = (WT_ADDR_WIDTH'(word_cnt + 1'b1) == words_q);
   assign pack_next = WT_W'({ld_data, pack} >> LOAD_W);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Load sequencing; beats are refused only while the final word is being written
   always_comb begin
      state_next  = state;
      ld_ready    = 1'b0;
      load_start  = 1'b0;
      load_finish = 1'b0;
      case (state)
         S_IDLE, S_READY: begin
            if (load_go) begin
               load_start = 1'b1;
               state_next = (cfg_load_words == '0) ? S_READY : S_LOAD;
            end
         end
         S_LOAD: begin
            if (wr_pend && last_wr) begin
               load_finish = 1'b1;
               state_next  = S_READY;
            end else begin
               ld_ready = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q        <= '0;
         words_q       <= '0;
         word_cnt      <= '0;
         fill_cnt      <= '0;
         beat_cnt      <= '0;
         wr_pend       <= 1'b0;
         wr_addr       <= '0;
         wr_word       <= '0;
         pack          <= '0;
         load_done     <= 1'b0;
         wt_data_ready <= 1'b0;
      end else begin
         load_done <= 1'b0;
         if (load_start) begin
            base_q   <= cfg_load_base;
            words_q  <= cfg_load_words;
            word_cnt <= '0;
            fill_cnt <= '0;
            beat_cnt <= '0;
            wr_pend  <= 1'b0;
            if (cfg_load_words == '0) begin
               load_done     <= 1'b1;
               wt_data_ready <= 1'b1;
            end else begin
               wt_data_ready <= 1'b0;
            end
         end else begin
            if (wr_pend) word_cnt <= word_cnt + 1'b1;
            if (load_finish) begin
               load_done     <= 1'b1;
               wt_data_ready <= 1'b1;
            end
            wr_pend <= 1'b0;
            if (beat_fire) begin
               pack <= pack_next;
               if (beat_cnt == BEAT_CW'(BEATS_PER_WORD - 1)) begin
                  beat_cnt <= '0;
                  wr_pend  <= 1'b1;
                  wr_word  <= pack_next;
                  wr_addr  <= base_q + fill_cnt;
                  fill_cnt <= fill_cnt + 1'b1;
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_pend) ram[wr_addr] <= wr_word;
   end

   always_ff @(posedge clk) begin
      if (wt_rd_en) addr_q <= wt_rd_addr;
   end

   // Read pipe: address register, RAM read, then output stages that only load on valid
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= 1'b0;
         rv    <= '0;
         for (int i = 0; i < NS; i++) rd_pipe[i] <= '0;
      end else begin
         acc_q <= wt_rd_en && wt_data_ready;
         rv[0] <= acc_q;
         if (acc_q) rd_pipe[0] <= ram[addr_q];
         for (int i = 1; i < NS; i++) begin
            rv[i] <= rv[i-1];
            if (rv[i-1]) rd_pipe[i] <= rd_pipe[i-1];
         end
      end
   end

   assign wt_rd_valid = rv[NS-1];
   assign wt_rd_data  = rd_pipe[NS-1];

   always_ff @(posedge clk) begin
      if (rst)                             rd_err <= 1'b0;
      else if (wt_rd_en && !wt_data_ready) rd_err <= 1'b1;
   end

`ifdef WT_MGR_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst)            load_checksum <= '0;
      else if (load_start) load_checksum <= '0;
      else if (beat_fire)  load_checksum <= load_checksum + 32'(ld_data);
   end
`endif

endmodule

// File: tb/tb_conv_weight_manager.sv
// Scoreboard bench for conv_weight_manager: random loads/reads against an array-based RAM model.
// Checksum checks are compiled in when WT_MGR_CHECKSUM_EN is defined.
module tb_conv_weight_manager;

   localparam int AW  = 12;
   localparam int LAT = 3;
   localparam int LW  = 64;
   localparam int BPW = 9;
   localparam int WW  = LW * BPW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] cfg_load_base = '0, cfg_load_words = '0;
   logic          load_go = 1'b0, ld_valid = 1'b0, ld_ready;
   logic [LW-1:0] ld_data = '0;
   logic          load_done, wt_data_ready;
   logic          wt_rd_en = 1'b0;
   logic [AW-1:0] wt_rd_addr = '0;
   logic          wt_rd_valid;
   logic [WW-1:0] wt_rd_data;
   logic          rd_err;
`ifdef WT_MGR_CHECKSUM_EN
   logic [31:0]   load_checksum;
`endif

   conv_weight_manager dut (
      .clk(clk), .rst(rst),
      .cfg_load_base(cfg_load_base), .cfg_load_words(cfg_load_words),
      .load_go(load_go), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .load_done(load_done), .wt_data_ready(wt_data_ready),
      .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
      .wt_rd_valid(wt_rd_valid), .wt_rd_data(wt_rd_data),
`ifdef WT_MGR_CHECKSUM_EN
      .load_checksum(load_checksum),
`endif
      .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] data;
      int            due;
      int            addr;
   } exp_t;

   exp_t          exp_q[$];
   logic [WW-1:0] model_mem [int];
   int            loaded[$];
   bit            model_ready = 1'b0;
   bit            model_err = 1'b0;
   logic [31:0]   model_sum = '0;
   int            checks = 0, errors = 0, cyc = 0, done_cnt = 0;
   int            dur_norm, dur_tog, dur_tmp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents read data
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && wt_rd_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
            end else begin
               e = exp_q.pop_front();
               check_output($sformatf("rd_data_%03h", e.addr), wt_rd_data, e.data);
               check_output("rd_latency", cyc, e.due);
            end
         end
         if (!rst && load_done) done_cnt++;
      end
   end

   task automatic issue_read(input int addr);
      wt_rd_en   = 1'b1;
      wt_rd_addr = AW'(addr);
      if (model_ready) exp_q.push_back('{model_mem[addr], cyc + LAT, addr});
      else             model_err = 1'b1;
      tick();
   endtask

   task automatic drain();
      wt_rd_en = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      check_output("drain_empty", exp_q.size(), 0);
   endtask

   // mode 0: beat k carries k; mode 1: random beats; mode 2: random beats with ld_valid toggling
   task automatic run_load(input int base, input int words, input int mode, input int abort_at,
                           output int dur);
      logic [LW-1:0] beats[$];
      logic [LW-1:0] d;
      logic [WW-1:0] w;
      int            prev_done, start, n;
      dur            = 0;
      wt_rd_en       = 1'b0;
      cfg_load_base  = AW'(base);
      cfg_load_words = AW'(words);
      load_go        = 1'b1;
      prev_done      = done_cnt;
      start          = cyc;
      model_sum      = '0;
      if (words != 0) model_ready = 1'b0;
      tick();
      load_go = 1'b0;
      if (words == 0) begin
         check_output("empty_load_done", load_done, 1'b1);
         check_output("empty_load_ready", wt_data_ready, 1'b1);
         model_ready = 1'b1;
         tick();
         check_output("empty_load_done_pulse", load_done, 1'b0);
         check_output("empty_load_ld_ready", ld_ready, 1'b0);
         return;
      end
      for (int b = 0; b < words * BPW; b++) begin
         if (abort_at >= 0 && b == abort_at) begin
            ld_valid = 1'b0;
            rst = 1'b1;
            tick();
            tick();
            rst = 1'b0;
            model_ready = 1'b0;
            model_err   = 1'b0;
            model_sum   = '0;
            exp_q.delete();
            return;
         end
         d = (mode == 0) ? LW'(b) : {$urandom, $urandom};
         ld_valid = 1'b1;
         ld_data  = d;
         n = 0;
         while (!ld_ready && n < 50) begin
            tick();
            n++;
         end
         if (n == 50) check_output("ld_ready_timeout", ld_ready, 1'b1);
         tick();
         beats.push_back(d);
         model_sum += d[31:0];
         if (mode == 2) begin
            ld_valid = 1'b0;
            tick();
         end
      end
      ld_valid = 1'b0;
      n = 0;
      while (done_cnt == prev_done && n < 50) begin
         tick();
         n++;
      end
      dur = cyc - start;
      tick();
      tick();
      check_output("load_done_count", done_cnt, prev_done + 1);
      check_output("ready_after_load", wt_data_ready, 1'b1);
      check_output("ld_ready_after_load", ld_ready, 1'b0);
`ifdef WT_MGR_CHECKSUM_EN
      check_output("load_checksum", load_checksum, model_sum);
`endif
      for (int j = 0; j < words; j++) begin
         for (int b = 0; b < BPW; b++) w[b*LW +: LW] = beats[j*BPW + b];
         model_mem[(base + j) % (1 << AW)] = w;
         loaded.push_back((base + j) % (1 << AW));
      end
      model_ready = 1'b1;
   endtask

   task automatic apply_stimulus();
      int a;
      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_output("reset_ld_ready", ld_ready, 1'b0);
      check_output("reset_load_done", load_done, 1'b0);
      check_output("reset_ready", wt_data_ready, 1'b0);
      check_output("reset_rd_valid", wt_rd_valid, 1'b0);
      check_output("reset_rd_data", wt_rd_data, '0);
      check_output("reset_rd_err", rd_err, 1'b0);

      // Read before any load is rejected and flags rd_err
      issue_read(5);
      wt_rd_en = 1'b0;
      check_output("rd_err_set", rd_err, model_err);
      repeat (6) tick();

      // Directed load with beat index data, then single and back-to-back reads
      run_load(16'h010, 2, 0, -1, dur_tmp);
      check_output("rd_err_sticky", rd_err, model_err);
      issue_read(16'h011);
      drain();
      issue_read(16'h010);
      issue_read(16'h011);
      issue_read(16'h010);
      drain();
      repeat (3) tick();
      check_output("rd_valid_idle", wt_rd_valid, 1'b0);
      check_output("rd_data_hold", wt_rd_data, model_mem[16'h010]);

      // Address wrap at the top of the RAM
      run_load(16'hFFF, 2, 1, -1, dur_tmp);
      issue_read(16'hFFF);
      issue_read(16'h000);
      drain();

      // Throughput comparison: steady beats versus ld_valid toggling
      run_load(16'h100, 1, 1, -1, dur_norm);
      run_load(16'h101, 1, 2, -1, dur_tog);
      check_output("steady_load_fast", dur_norm <= 14, 1'b1);
      check_output("toggle_load_slow", dur_tog >= 2 * BPW, 1'b1);
      issue_read(16'h100);
      issue_read(16'h101);
      drain();

      // Zero-word load
      run_load(16'h050, 0, 1, -1, dur_tmp);

      // A read in flight when load_go arrives returns pre-load data
      issue_read(16'h010);
      run_load(16'h200, 1, 1, -1, dur_tmp);
      drain();

      // Reset mid-load, then a fresh one-word load
      check_output("rd_err_before_rst", rd_err, model_err);
      run_load(16'h300, 3, 1, 5, dur_tmp);
      check_output("midload_rst_ready", wt_data_ready, 1'b0);
      check_output("midload_rst_rd_err", rd_err, 1'b0);
      check_output("midload_rst_ld_ready", ld_ready, 1'b0);
      run_load(16'h300, 1, 1, -1, dur_tmp);
      issue_read(16'h300);
      drain();

      // Random loads and random read bursts over everything loaded so far
      for (int it = 0; it < 4; it++) begin
         run_load($urandom_range(0, (1 << AW) - 1), $urandom_range(1, 3), 1, -1, dur_tmp);
         for (int r = 0; r < 8; r++) begin
            a = loaded[$urandom_range(0, loaded.size() - 1)];
            issue_read(a);
            if ($urandom_range(0, 2) == 0) begin
               wt_rd_en = 1'b0;
               tick();
            end
         end
         drain();
      end
      check_output("final_rd_err", rd_err, model_err);
   endtask

   initial begin
      apply_stimulus();
      repeat (4) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
